// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared count type and the in-order retire helper for the
// multi-lane dispatch stage.
//
// LANES_MAX is the widest LANES this build instantiates. cnt_t is sized
// from it so that every count (0..LANES) fits without overflow, including
// the intermediate sums slot+acc and keep+j used to steer the slot muxes
// (at most 2*LANES-1).
package dispatch_pkg;

  localparam int LANES_MAX = 2;
  localparam int CNT_W     = $clog2(LANES_MAX) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Length of the longest prefix of slots that are both valid and accepted.
  // A refused slot ends the prefix, so later handshakes are ignored.
  function automatic cnt_t prefix_len(input logic [LANES_MAX-1:0] valid,
                                      input logic [LANES_MAX-1:0] ready);
    cnt_t n;
    logic run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < LANES_MAX; i++) begin
      if (run && valid[i] && ready[i]) begin
        n = n + cnt_t'(1);
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/dispatch_checker.sv
// dispatch_checker: simulation-only property checks for fifo_dispatch_stage.
// Holds no state and drives nothing.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   ready_cnt   FIFO entries offered
//   poll_cnt    FIFO entries taken
//   occupancy   live slot count
//   lane_valid  per-slot valid vector
module dispatch_checker #(
  parameter int LANES = 2
) (
  input logic                     clk,
  input logic                     rst,
  input logic [$clog2(LANES):0]   ready_cnt,
  input logic [$clog2(LANES):0]   poll_cnt,
  input logic [$clog2(LANES):0]   occupancy,
  input logic [LANES-1:0]         lane_valid
);

  localparam int             PW      = $clog2(LANES) + 1;
  localparam logic [PW-1:0]  LANES_C = PW'(LANES);

  logic [LANES-1:0] therm_s;

  // Thermometer pattern implied by the current occupancy.
  always_comb begin
    therm_s = '0;
    for (int i = 0; i < LANES; i++) begin
      therm_s[i] = (PW'(i) < occupancy);
    end
  end

  a_poll_le_ready: assert property (@(posedge clk) disable iff (rst)
    poll_cnt <= ready_cnt);

  a_occ_le_lanes: assert property (@(posedge clk) disable iff (rst)
    occupancy <= LANES_C);

  a_valid_thermo: assert property (@(posedge clk) disable iff (rst)
    (((lane_valid + LANES'(1)) & lane_valid) == '0) && (lane_valid == therm_s));

endmodule

// File: rtl/dispatch_shift_slots.sv
// dispatch_shift_slots: LANES-deep holding register for the dispatch stage.
// Each cycle the surviving entries shift down by acc (oldest stays in slot 0)
// and poll entries from the FIFO are appended directly behind them.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset, clears all slots to 0
//   acc        entries retired this cycle (prefix of slots)
//   keep       entries surviving this cycle (occupancy - acc)
//   poll       entries taken from the FIFO this cycle
//   fifo_data  FIFO data_out[], [0] oldest
//   slot_data  registered slot contents, slot 0 oldest
module dispatch_shift_slots
  import dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  cnt_t                             acc,
  input  cnt_t                             keep,
  input  cnt_t                             poll,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] fifo_data,
  output logic [LANES-1:0][DATA_WIDTH-1:0] slot_data
);

  logic [LANES-1:0][DATA_WIDTH-1:0] slot_r;
  logic [LANES-1:0][DATA_WIDTH-1:0] next_s;
  logic [LANES-1:0][DATA_WIDTH-1:0] shifted_s;
  logic [LANES-1:0][DATA_WIDTH-1:0] appended_s;

  // Next slot contents: shift survivors down, append polled entries,
  // leave dead slots untouched. The source selects are one-hot, so an
  // OR-reduction over candidates forms each mux.
  always_comb begin
    next_s     = slot_r;
    shifted_s  = '0;
    appended_s = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int s = 0; s < LANES; s++) begin
        shifted_s[i] = shifted_s[i] |
                       ((cnt_t'(s) == cnt_t'(i) + acc) ? slot_r[s] : {DATA_WIDTH{1'b0}});
      end
      for (int j = 0; j < LANES; j++) begin
        appended_s[i] = appended_s[i] |
                        (((cnt_t'(i) == keep + cnt_t'(j)) && (cnt_t'(j) < poll)) ?
                         fifo_data[j] : {DATA_WIDTH{1'b0}});
      end
      if (cnt_t'(i) < keep) begin
        next_s[i] = shifted_s[i];
      end else if (cnt_t'(i) < keep + poll) begin
        next_s[i] = appended_s[i];
      end else begin
        next_s[i] = slot_r[i];
      end
    end
  end

  // Slot register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r <= '0;
    end else begin
      slot_r <= next_s;
    end
  end

  assign slot_data = slot_r;

endmodule

// File: rtl/fifo_dispatch_stage.sv
// fifo_dispatch_stage: in-order multi-lane dispatch stage fed by a multi-pop
// synchronous FIFO. Pulls up to LANES entries per cycle into a holding
// register (oldest in slot 0), presents slot i on lane i, and retires the
// longest accepted prefix each cycle. Retired slots are refilled in the
// same cycle, so a fully-ready downstream sees no bubbles.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset (dominates flush)
//   ready_cnt     FIFO entries available, 0..LANES
//   fifo_data     FIFO data_out[], [0] oldest
//   poll_cnt      entries consumed from the FIFO this cycle (combinational)
//   flush         discard all held entries after this cycle's handshakes
//   lane_valid    registered; slot i live (thermometer code)
//   lane_data     registered slot contents
//   lane_ready    lane i accepts slot i
//   occupancy     registered live slot count
//   stall_cycles  (DISPATCH_PERF_CNT_EN) cycles with live entries and no retire
//   retired_total (DISPATCH_PERF_CNT_EN) running count of retired entries
//
// Optional feature macro: DISPATCH_PERF_CNT_EN adds the two perf counters.
module fifo_dispatch_stage
  import dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]                      stall_cycles,
  output logic [31:0]                      retired_total,
`endif
  input  logic [$clog2(LANES):0]           ready_cnt,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] fifo_data,
  output logic [$clog2(LANES):0]           poll_cnt,
  input  logic                             flush,
  output logic [LANES-1:0]                 lane_valid,
  output logic [LANES-1:0][DATA_WIDTH-1:0] lane_data,
  input  logic [LANES-1:0]                 lane_ready,
  output logic [$clog2(LANES):0]           occupancy
);

  localparam cnt_t LANES_C = cnt_t'(LANES);

  cnt_t                 occ_r;
  logic [LANES-1:0]     valid_r;
  cnt_t                 acc_s;
  cnt_t                 keep_s;
  cnt_t                 room_s;
  cnt_t                 avail_s;
  cnt_t                 poll_s;
  cnt_t                 occ_next_s;
  logic [LANES-1:0]     valid_next_s;
  logic [LANES_MAX-1:0] valid_ext_s;
  logic [LANES_MAX-1:0] ready_ext_s;

  // Retire/refill counts. poll is forced to 0 in reset and on flush so the
  // FIFO is never popped for entries that would be thrown away.
  always_comb begin
    valid_ext_s              = '0;
    ready_ext_s              = '0;
    valid_ext_s[LANES-1:0]   = valid_r;
    ready_ext_s[LANES-1:0]   = lane_ready;
    acc_s                    = prefix_len(valid_ext_s, ready_ext_s);
    keep_s                   = occ_r - acc_s;
    room_s                   = LANES_C - keep_s;
    avail_s                  = cnt_t'(ready_cnt);
    if (rst || flush) begin
      poll_s = '0;
    end else if (avail_s < room_s) begin
      poll_s = avail_s;
    end else begin
      poll_s = room_s;
    end
    if (flush) begin
      occ_next_s = '0;
    end else begin
      occ_next_s = keep_s + poll_s;
    end
    valid_next_s = '0;
    for (int i = 0; i < LANES; i++) begin
      valid_next_s[i] = (cnt_t'(i) < occ_next_s);
    end
  end

  // Occupancy and its thermometer-coded valid vector, kept as separate
  // registers so lane_valid is a direct flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r   <= '0;
      valid_r <= '0;
    end else begin
      occ_r   <= occ_next_s;
      valid_r <= valid_next_s;
    end
  end

  dispatch_shift_slots #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .acc       (acc_s),
    .keep      (keep_s),
    .poll      (poll_s),
    .fifo_data (fifo_data),
    .slot_data (lane_data)
  );

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_r;
  logic [31:0] retired_r;

  // Perf counters; free-running with wrap, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r   <= 32'd0;
      retired_r <= 32'd0;
    end else begin
      stall_r   <= stall_r + (((occ_r != '0) && (acc_s == '0)) ? 32'd1 : 32'd0);
      retired_r <= retired_r + 32'(acc_s);
    end
  end

  assign stall_cycles  = stall_r;
  assign retired_total = retired_r;
`endif

  assign poll_cnt   = poll_s[$clog2(LANES):0];
  assign occupancy  = occ_r[$clog2(LANES):0];
  assign lane_valid = valid_r;

  dispatch_checker #(
    .LANES (LANES)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .ready_cnt  (ready_cnt),
    .poll_cnt   (poll_cnt),
    .occupancy  (occupancy),
    .lane_valid (lane_valid)
  );

endmodule

// File: tb/tb_fifo_dispatch_stage.sv
// Bench for fifo_dispatch_stage: a queue stands in for the multi-pop FIFO,
// and a scoreboard queue holds every pushed entry in order; entries are
// popped and compared as the DUT retires them.
module tb_fifo_dispatch_stage;

  localparam int LANES = 2;
  localparam int DW    = 8;
  localparam int CW    = $clog2(LANES) + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [CW-1:0]            ready_cnt;
  logic [LANES-1:0][DW-1:0] fifo_data;
  logic [CW-1:0]            poll_cnt;
  logic                     flush;
  logic [LANES-1:0]         lane_valid;
  logic [LANES-1:0][DW-1:0] lane_data;
  logic [LANES-1:0]         lane_ready;
  logic [CW-1:0]            occupancy;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]              stall_cycles;
  logic [31:0]              retired_total;
  logic [31:0]              base_stall;
  logic [31:0]              base_ret;
`endif

  always #5 clk = ~clk;

  fifo_dispatch_stage #(
    .DATA_WIDTH (DW),
    .LANES      (LANES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef DISPATCH_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .retired_total (retired_total),
`endif
    .ready_cnt     (ready_cnt),
    .fifo_data     (fifo_data),
    .poll_cnt      (poll_cnt),
    .flush         (flush),
    .lane_valid    (lane_valid),
    .lane_data     (lane_data),
    .lane_ready    (lane_ready),
    .occupancy     (occupancy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_occ    = 0;
  logic [31:0] m_stall  = 32'd0;
  logic [31:0] m_ret    = 32'd0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    sb_q.push_back(d);
  endtask

  task automatic drive_fifo();
    int n;
    n = (fifo_q.size() < LANES) ? fifo_q.size() : LANES;
    ready_cnt = CW'(n);
    for (int j = 0; j < LANES; j++) begin
      fifo_data[j] = (j < fifo_q.size()) ? fifo_q[j] : '0;
    end
  endtask

  // One reset cycle; called at a negedge, returns at the next negedge.
  task automatic rst_cycle();
    rst        = 1'b1;
    flush      = 1'b0;
    lane_ready = '1;
    drive_fifo();
    #1;
    check_eq("rst_poll", poll_cnt, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_valid", lane_valid, 0);
    check_eq("rst_data", lane_data, 0);
    @(negedge clk);
  endtask

  // One operating cycle with model checks; negedge to negedge.
  task automatic cycle(input logic [LANES-1:0] rdy, input logic fl);
    int acc, keep, avail, exp_poll;
    logic [LANES-1:0] therm;
    logic [DW-1:0]    exp_d;
    rst        = 1'b0;
    lane_ready = rdy;
    flush      = fl;
    drive_fifo();
    #1;
    therm = '0;
    for (int i = 0; i < LANES; i++) therm[i] = (i < m_occ);
    check_eq("occupancy", occupancy, m_occ);
    check_eq("lane_valid", lane_valid, therm);
    for (int i = 0; i < m_occ; i++) check_eq("hold_data", lane_data[i], sb_q[i]);
    acc = 0;
    while (acc < m_occ && rdy[acc]) acc++;
    for (int i = 0; i < acc; i++) begin
      exp_d = sb_q.pop_front();
      check_eq("retire_data", lane_data[i], exp_d);
    end
    keep     = m_occ - acc;
    avail    = (fifo_q.size() < LANES) ? fifo_q.size() : LANES;
    exp_poll = fl ? 0 : (((LANES - keep) < avail) ? (LANES - keep) : avail);
    check_eq("poll_cnt", poll_cnt, exp_poll);
    if (m_occ > 0 && acc == 0) m_stall = m_stall + 32'd1;
    m_ret = m_ret + 32'(acc);
    if (fl) begin
      for (int i = 0; i < keep; i++) void'(sb_q.pop_front());
      m_occ = 0;
    end else begin
      for (int i = 0; i < exp_poll; i++) void'(fifo_q.pop_front());
      m_occ = keep + exp_poll;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [LANES-1:0] rdy;
    logic             fl;
    rst        = 1'b1;
    flush      = 1'b0;
    lane_ready = '0;
    ready_cnt  = '0;
    fifo_data  = '0;
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    repeat (3) rst_cycle();

    // Back-to-back delivery with all lanes ready.
    cycle(2'b11, 1'b0);
    check_eq("t2_pair", {lane_valid, lane_data}, {2'b11, 16'h2211});
    cycle(2'b11, 1'b0);
    check_eq("t2_third", {lane_valid, lane_data[0]}, {2'b01, 8'h33});
    cycle(2'b11, 1'b0);

    // Out-of-order ready is ignored; partial retire shifts and refills.
    push(8'h11); push(8'h22); push(8'h33);
    cycle(2'b00, 1'b0);
    cycle(2'b10, 1'b0);
    check_eq("t3_hold", {lane_valid, lane_data}, {2'b11, 16'h2211});
    cycle(2'b01, 1'b0);
    check_eq("t4_shift", {lane_valid, lane_data}, {2'b11, 16'h3322});
    cycle(2'b11, 1'b0);

    // Flush with handshakes and FIFO data pending.
    push(8'hA0); push(8'hA1);
    cycle(2'b00, 1'b0);
    push(8'hB0); push(8'hB1);
    cycle(2'b11, 1'b1);
    check_eq("t5_flush", {occupancy, lane_valid}, 0);

    // Stall then retire.
    cycle(2'b00, 1'b0);
`ifdef DISPATCH_PERF_CNT_EN
    base_stall = stall_cycles;
    base_ret   = retired_total;
`endif
    repeat (3) cycle(2'b00, 1'b0);
    cycle(2'b11, 1'b0);
`ifdef DISPATCH_PERF_CNT_EN
    check_eq("t6_stall", stall_cycles - base_stall, 32'd3);
    check_eq("t6_retired", retired_total - base_ret, 32'd2);
`endif

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 6) push(DW'($urandom));
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) push(DW'($urandom));
      rdy = LANES'($urandom);
      fl  = ($urandom_range(0, 39) == 0);
      cycle(rdy, fl);
    end
    repeat (6) cycle(2'b11, 1'b0);
    check_eq("drain_occ", occupancy, 0);
`ifdef DISPATCH_PERF_CNT_EN
    check_eq("perf_stall", stall_cycles, m_stall);
    check_eq("perf_retired", retired_total, m_ret);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
